// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and default sizes for the serial adder
package serial_add_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational SLICE-bit ripple adder built from full adders
module add_slice
    import serial_add_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE];

endmodule

// File: rtl/serial_add16.sv
// rtl/serial_add16.sv - multi-cycle adder feeding one SLICE-bit chunk per clock, LSB first
module serial_add16
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_params
        $fatal(1, "serial_add16: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic [WIDTH-1:0]   sum_shifted;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic [SLICE-1:0]   slice_sum;
    logic               slice_cout;

    add_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_sh[SLICE-1:0]),
        .b    (b_sh[SLICE-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // New slice result enters at the top; after NSLICE steps the LSB chunk has reached bit 0.
    assign sum_shifted = (WIDTH'(slice_sum) << (WIDTH - SLICE)) | (sum_sh >> SLICE);
    assign last        = (cnt == CNT_W'(NSLICE - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY) || (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        b_sh  <= in_b;
                        carry <= in_cin;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> SLICE;
                    b_sh   <= b_sh >> SLICE;
                    sum_sh <= sum_shifted;
                    carry  <= slice_cout;
                    if (last) begin
                        out_sum  <= sum_shifted;
                        out_cout <= slice_cout;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add16.sv
// tb/tb_serial_add16.sv - directed and randomized self-checking bench for serial_add16
module tb_serial_add16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        busy;

    int total = 0;
    int bad   = 0;

    serial_add16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for the result, optional backpressure, handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int stall, input bit rdy_busy, input bit toggle);
        int          n;
        logic [16:0] exp;
        logic [15:0] held_sum;
        logic        held_cout;
        exp = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        n = 0;
        while (!in_ready && n < 100) begin
            step;
            n++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_valid  = 1'b1;
        out_ready = rdy_busy;
        step;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            if (toggle) begin
                in_valid = n[0];
                in_a     = 16'hAAAA;
                in_b     = 16'hAAAA;
                in_cin   = 1'b1;
                chk("in_ready_busy", in_ready, 0);
            end
            step;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", n, 8);
        chk("sum", out_sum, exp[15:0]);
        chk("cout", out_cout, exp[16]);
        held_sum  = out_sum;
        held_cout = out_cout;
        out_ready = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            step;
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, held_sum);
            chk("hold_cout", out_cout, held_cout);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("sum_kept", out_sum, exp[15:0]);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        step;
        step;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_busy", busy, 0);
        #2;
        rst_n = 1'b1;
        step;
        chk("rst_in_ready", in_ready, 1);

        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b1, 5, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b1, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0, 1'b1);

        // Reset in the middle of an operation.
        in_a     = 16'h0F0F;
        in_b     = 16'h7777;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        step;
        step;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_cout", out_cout, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step;
        run_op(16'h0003, 16'h0005, 1'b0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
